fft_result_streamer: RTL

- Sits at the output end of RecursiveFFT; the counterpart of loading samples into it.
- On a start pulse, snapshots all N complex bins of the wide parallel FFT result X.
- Scales and narrows each bin back to the W-bit fixed-point sample format.
- Streams bins out one per beat in natural index order over a valid/ready handshake, so downstream logic consumes serially.

---
 rtl/fft_result_streamer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fft_result_streamer.sv
// Snapshots a parallel FFT result and streams the N bins out serially over valid/ready.
// Optional build macro FFT_STREAM_SAT_EN: saturate instead of wrap when narrowing to W bits.
module fft_result_streamer #(
    parameter int N     = 16,
    parameter int W     = 16,
    parameter int XW    = W + N,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [XW-1:0] X [N][2],
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [W-1:0]  out_re,
    output logic signed [W-1:0]  out_im,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 done
);
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state, state_nx;
    logic                  hs, capture, advance, finish;
    logic [IW-1:0]         idx_nx;
    logic signed [XW-1:0]  snap [N][2];

    function automatic logic signed [W-1:0] scale(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] s;
        s = v >>> SHIFT;
`ifdef FFT_STREAM_SAT_EN
        if (s > $signed({{(XW-W+1){1'b0}}, {(W-1){1'b1}}}))
            return {1'b0, {(W-1){1'b1}}};
        else if (s < $signed({{(XW-W+1){1'b1}}, {(W-1){1'b0}}}))
            return {1'b1, {(W-1){1'b0}}};
        else
            return s[W-1:0];
`else
        return s[W-1:0];
`endif
    endfunction

    assign hs     = out_valid && out_ready;
    assign idx_nx = out_idx + IW'(1);

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        advance  = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture  = 1'b1;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                if (hs) begin
                    if (out_idx != IW'(N-1)) begin
                        advance = 1'b1;
                    end else if (start) begin
                        // back-to-back frame: recapture on the last handshake, no bubble
                        capture = 1'b1;
                    end else begin
                        finish   = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                snap[k][0] <= '0;
                snap[k][1] <= '0;
            end
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= hs && out_last;
            if (capture) begin
                for (int k = 0; k < N; k++) begin
                    snap[k][0] <= X[k][0];
                    snap[k][1] <= X[k][1];
                end
                out_re    <= scale(X[0][0]);
                out_im    <= scale(X[0][1]);
                out_idx   <= '0;
                out_last  <= 1'b0;
                out_valid <= 1'b1;
                busy      <= 1'b1;
            end else if (advance) begin
                out_re   <= scale(snap[idx_nx][0]);
                out_im   <= scale(snap[idx_nx][1]);
                out_idx  <= idx_nx;
                out_last <= (idx_nx == IW'(N-1));
            end else if (finish) begin
                out_valid <= 1'b0;
                busy      <= 1'b0;
                out_last  <= 1'b0;
                out_re    <= '0;
                out_im    <= '0;
                out_idx   <= '0;
            end
        end
    end

endmodule
